uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first; counterpart to the team's existing uart_tx / uart_tx_stream path.
- Oversamples the asynchronous rx pin with a local clock.
- Presents each received byte on a valid/ready output port.
- Flags framing errors and overruns.
- Sits at the board serial input, feeding command parsers and loopback checks.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit period. Legal range is 4..65535.
- STOP_BITS, 1: number of stop bits checked. Legal values are 1 or 2.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-period counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; asynchronous; idles high.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  byte available.
- ready  in  1  consumer accepts the byte when valid&&ready on a clk edge.
- frame_err  out  1  one-cycle pulse: a sampled stop bit was 0.
- overrun  out  1  one-cycle pulse: a byte completed while valid=1 and ready=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE; sync flops=1; data=0.
  - valid=0, frame_err=0, overrun=0, busy=0.
  - All counters 0.
  - Asserting rst mid-frame aborts the frame; no partial byte is ever delivered.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s. Pin-to-rx_s latency is 2 clk.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each clk.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - Sample 1 -> IDLE (glitch rejected, no flag).
  - Sample 0 -> DATA, cnt=0, bit_idx=0.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] and reset cnt.
  - bit_idx increments per sample.
  - After bit_idx 7 is sampled -> STOP, stop_idx=0.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - Sample 0 -> frame_err pulses the next cycle, byte discarded, -> BREAK.
  - Sample 1 with stop_idx<STOP_BITS-1 -> stop_idx++.
  - Sample 1 on the final stop bit -> deliver, -> IDLE.
  - STOP returns to IDLE at mid-stop-bit, allowing back-to-back frames without stop-bit slack.
- BREAK:
  - Waits for rx_s==1, then -> IDLE.
  - No start is detected while the line is held low.
- Deliver, on the clk after the final stop sample:
  - If valid==0, or ready==1 in that same cycle: data<=shift, valid<=1.
  - Otherwise: overrun pulses 1 cycle, the new byte is dropped, and the old data/valid are held.
- Handshake:
  - valid is deasserted on the edge where valid&&ready, unless a deliver occurs in the same cycle. In that case valid stays 1 and data takes the new byte.
  - data never changes while valid=1 and ready=0.
- Latency: start-bit falling edge at the pin -> valid=1 after 2 + 1 + CLKS_PER_BIT/2 + (8+STOP_BITS-1)*CLKS_PER_BIT + CLKS_PER_BIT + 1 clk cycles, ±1 for pin phase.
- Widths: cnt is CNT_W bits and never wraps past CLKS_PER_BIT-1; bit_idx is 3 bits; stop_idx is 1 bit.

Decomposition:
- Shared uart_pkg include holds:
  - State encodings: IDLE, START, DATA, STOP, BREAK (3 bits).
  - DATA_BITS=8.
  - The half-bit and full-bit compare constants derived from CLKS_PER_BIT.
- Sub-module uart_rx_sync: 2-flop synchroniser, reset value 1, instantiated once.

Test Plan (CLKS_PER_BIT=16, STOP_BITS=1, driven by uart_tx-style bit model):
- Send 0xA5 with ready=1 -> valid pulses 1 cycle with data=0xA5; frame_err=0; busy falls back to 0.
- Send 0x00, 0xFF, 0x55 back-to-back with ready held 0 -> first byte 0x00 is held; overrun pulses twice; after ready=1, data=0x00 and valid drops.
- 5-clk low glitch on idle rx -> returns to IDLE from START; no valid, no frame_err; next frame 0x3C received correctly.
- Send 0x81 with the stop bit forced 0, then hold rx low for 40 bits -> frame_err pulses once; no valid; no further starts while low; after rx=1, 0x42 is received.
- Assert rst at the middle of bit 4 of 0x96 -> all outputs 0 asynchronously; after release, the next frame 0x69 is received intact and no 0x96 appears.
- Bit-rate tolerance: sender at +3% and -3% of CLKS_PER_BIT, sending 0x00..0xFF -> all 256 bytes match; no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding and bit-timing helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int DATA_BITS = 8;

    // Counter value at which the start bit is re-checked (middle of the start bit).
    function automatic int half_bit_cmp(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

    // Counter value at which each later bit is sampled (one full bit after the last sample).
    function automatic int full_bit_cmp(input int clks_per_bit);
        return clks_per_bit - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous rx pin
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [1:0] sync_q;

    // Resets to 1 so an idle-high line never looks like a start bit out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver with valid/ready byte output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit_cmp(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(full_bit_cmp(CLKS_PER_BIT));
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 deliver;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    // Frame FSM plus output handshake; deliver is raised by the final stop
    // sample and acted on one clock later so the byte lands with its flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            deliver   <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            deliver   <= 1'b0;

            if (deliver) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            state    <= ST_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end else if (STOP_BITS == 2 && stop_idx == 1'b0) begin
                            stop_idx <= 1'b1;
                        end else begin
                            deliver <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a byte scoreboard
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int  CPB    = 16;
    localparam real BIT_NS = CPB * 10.0;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int rise_cyc = -1;
    logic [7:0] exp_q[$];

    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_fe    = 1'b0;
    logic       p_ov    = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte must be the next one the bench expects,
    // held bytes must not change, and flag pulses must be single-cycle.
    always @(negedge clk) begin
        if (rst) begin
            p_valid = 1'b0;
            p_fe    = 1'b0;
            p_ov    = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                check("hold_valid", int'(valid), 1);
                check("hold_data", int'(data), int'(p_data));
            end
            if (valid && !p_valid) rise_cyc = cyc;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", data);
                end else begin
                    check("rx_byte", int'(data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                fe_cnt++;
                check("fe_width", int'(p_fe), 0);
            end
            if (overrun) begin
                ov_cnt++;
                check("ov_width", int'(p_ov), 0);
            end
            p_valid = valid;
            p_ready = ready;
            p_fe    = frame_err;
            p_ov    = overrun;
            p_data  = data;
        end
    end

    task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_val);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
        if (stop_val) rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_cyc;
        int lat;
        int fe0;
        int ov0;

        // Reset state
        idle_cycles(4);
        @(negedge clk);
        check("rst_valid", int'(valid), 0);
        check("rst_fe", int'(frame_err), 0);
        check("rst_ov", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(4);

        // Single byte, consumer ready, plus latency from start edge
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        fall_cyc = cyc;
        send_frame(8'hA5, BIT_NS, 1'b1);
        wait_drain("t1_drain", 64);
        idle_cycles(4);
        lat = rise_cyc - fall_cyc;
        check("t1_latency_in_window", int'(lat >= 155 && lat <= 157), 1);
        check("t1_fe", fe_cnt - fe0, 0);
        check("t1_ov", ov_cnt - ov0, 0);
        check("t1_valid", int'(valid), 0);
        check("t1_busy", int'(busy), 0);

        // Three back-to-back bytes with the consumer stalled
        ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h00);
        send_frame(8'h00, BIT_NS, 1'b1);
        send_frame(8'hFF, BIT_NS, 1'b1);
        send_frame(8'h55, BIT_NS, 1'b1);
        idle_cycles(20);
        check("t2_overruns", ov_cnt - ov0, 2);
        check("t2_valid_held", int'(valid), 1);
        check("t2_data_held", int'(data), 8'h00);
        ready = 1'b1;
        wait_drain("t2_drain", 8);
        idle_cycles(2);
        check("t2_valid_drop", int'(valid), 0);

        // Short glitch on an idle line is rejected
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        idle_cycles(40);
        check("t3_busy", int'(busy), 0);
        check("t3_valid", int'(valid), 0);
        check("t3_fe", fe_cnt - fe0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, BIT_NS, 1'b1);
        wait_drain("t3_drain", 64);

        // Framing error followed by a long break
        idle_cycles(4);
        fe0 = fe_cnt;
        send_frame(8'h81, BIT_NS, 1'b0);
        #(40 * BIT_NS);
        check("t4_fe", fe_cnt - fe0, 1);
        check("t4_busy_break", int'(busy), 1);
        check("t4_valid", int'(valid), 0);
        rx = 1'b1;
        #(2 * BIT_NS);
        check("t4_busy_idle", int'(busy), 0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, BIT_NS, 1'b1);
        wait_drain("t4_drain", 64);
        check("t4_fe_after", fe_cnt - fe0, 1);

        // Reset in the middle of bit 4 aborts the frame
        idle_cycles(4);
        fork
            send_frame(8'h96, BIT_NS, 1'b1);
            begin
                #(5.5 * BIT_NS);
                rst = 1'b1;
                #1;
                check("t5_valid", int'(valid), 0);
                check("t5_fe", int'(frame_err), 0);
                check("t5_ov", int'(overrun), 0);
                check("t5_busy", int'(busy), 0);
                check("t5_data", int'(data), 0);
            end
        join
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(4);
        exp_q.push_back(8'h69);
        send_frame(8'h69, BIT_NS, 1'b1);
        wait_drain("t5_drain", 64);

        // Bit-rate tolerance: +3% for the lower half, -3% for the upper half
        idle_cycles(4);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), (b < 128) ? BIT_NS * 1.03 : BIT_NS * 0.97, 1'b1);
            #20;
        end
        wait_drain("t6_drain", 64);
        check("t6_fe", fe_cnt - fe0, 0);
        check("t6_ov", ov_cnt - ov0, 0);
        idle_cycles(4);
        check("t6_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
